// File: rtl/event_scheduler.sv
// ---------------------------------------------------------------------------
// event_scheduler
//
// Write side of the delay-line timestamp FIFO. Rising edges on the
// asynchronous event_in level are synchronized, and on each accepted event
// the free-running timer value plus the programmed delay (clamped to at
// least MIN_DELAY, wrapping modulo 2^WIDTH) becomes a target count that is
// pushed into the FIFO. An entry that cannot be written before the timer
// reaches its target is dropped, as is any event arriving while an entry
// is still held.
//
// Ports:
//   clk         clock
//   n_reset     synchronous, active-low reset
//   enable      1 = accept new events, 0 = ignore edges
//   event_in    asynchronous event level, rising edge = event
//   count       free-running timer shared with the read stage
//   delay       programmed delay in clk cycles, sampled at acceptance
//   full        FIFO full flag
//   clr_status  synchronous clear of overflow and drop_count
//   wr_en       FIFO write strobe, one cycle per entry (registered)
//   data_out    target count written to the FIFO (registered)
//   pending     an accepted entry is waiting to be written
//   overflow    sticky, set on any dropped event
//   drop_count  saturating count of dropped events
// ---------------------------------------------------------------------------
module event_scheduler #(
    parameter int WIDTH     = 8,
    parameter int MIN_DELAY = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 enable,
    input  logic                 event_in,
    input  logic [WIDTH-1:0]     count,
    input  logic [WIDTH-1:0]     delay,
    input  logic                 full,
    input  logic                 clr_status,
    output logic                 wr_en,
    output logic [WIDTH-1:0]     data_out,
    output logic                 pending,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] drop_count
);

    localparam logic [WIDTH-1:0]     MIN_DELAY_V = WIDTH'(MIN_DELAY);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PEND  = 2'b01,
        WRITE = 2'b10
    } state_t;

    state_t           state_r;
    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    logic [WIDTH-1:0] target_r;

    logic             evt_s;
    logic             expired_s;
    logic             drop_s;
    logic [WIDTH-1:0] new_target_s;

    // Target = count + max(delay, MIN_DELAY); the sum wraps with no carry out.
    function automatic logic [WIDTH-1:0] calc_target(
        input logic [WIDTH-1:0] cnt,
        input logic [WIDTH-1:0] dly
    );
        logic [WIDTH-1:0] eff;
        if (dly < MIN_DELAY_V) begin
            eff = MIN_DELAY_V;
        end else begin
            eff = dly;
        end
        return cnt + eff;
    endfunction

    // Edge detect, candidate target and drop decision for the current cycle.
    always_comb begin
        evt_s        = s2_r & ~s3_r & enable;
        new_target_s = calc_target(count, delay);
        expired_s    = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            PEND: begin
                // Expiry drops the held entry; otherwise a new event is the
                // one dropped. Either way at most one drop per cycle.
                expired_s = (count == target_r);
                drop_s    = expired_s | evt_s;
            end
            default: begin
                expired_s = 1'b0;
                drop_s    = 1'b0;
            end
        endcase
    end

    // Three-stage synchronizer; s3 is the previous value of s2 for edge detect.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= event_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Entry FSM with registered write strobe, data and pending flag.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_r  <= IDLE;
            target_r <= {WIDTH{1'b0}};
            wr_en    <= 1'b0;
            data_out <= {WIDTH{1'b0}};
            pending  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state_r)
                IDLE, WRITE: begin
                    // An event during the write cycle is accepted normally.
                    if (evt_s) begin
                        target_r <= new_target_s;
                        state_r  <= PEND;
                        pending  <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        pending  <= 1'b0;
                    end
                end
                PEND: begin
                    if (expired_s) begin
                        if (evt_s) begin
                            target_r <= new_target_s;
                            state_r  <= PEND;
                            pending  <= 1'b1;
                        end else begin
                            state_r  <= IDLE;
                            pending  <= 1'b0;
                        end
                    end else if (!full) begin
                        data_out <= target_r;
                        wr_en    <= 1'b1;
                        state_r  <= WRITE;
                        pending  <= 1'b0;
                    end else begin
                        state_r  <= PEND;
                        pending  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow and saturating drop counter; a clear coinciding with a
    // drop leaves overflow low but records that single drop.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            overflow   <= 1'b0;
            drop_count <= {CNT_WIDTH{1'b0}};
        end else if (clr_status) begin
            overflow   <= 1'b0;
            drop_count <= drop_s ? CNT_ONE : {CNT_WIDTH{1'b0}};
        end else if (drop_s) begin
            overflow   <= 1'b1;
            drop_count <= (drop_count == CNT_MAX) ? drop_count : (drop_count + CNT_ONE);
        end else begin
            overflow   <= overflow;
            drop_count <= drop_count;
        end
    end

endmodule

// File: tb/tb_event_scheduler.sv
module tb_event_scheduler;

    localparam int W  = 8;
    localparam int MD = 4;
    localparam int CW = 8;

    logic          clk;
    logic          n_reset;
    logic          enable;
    logic          event_in;
    logic [W-1:0]  count;
    logic [W-1:0]  delay;
    logic          full;
    logic          clr_status;
    logic          wr_en;
    logic [W-1:0]  data_out;
    logic          pending;
    logic          overflow;
    logic [CW-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: sample history, one held entry, status.
    logic          h1, h2, h3;
    logic          m_held;
    logic [W-1:0]  m_tgt;
    logic          m_wr;
    logic [W-1:0]  m_data;
    logic          m_pend;
    logic          m_ovf;
    logic [CW-1:0] m_cnt;
    int            wr_seen;

    event_scheduler #(.WIDTH(W), .MIN_DELAY(MD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .n_reset(n_reset), .enable(enable), .event_in(event_in),
        .count(count), .delay(delay), .full(full), .clr_status(clr_status),
        .wr_en(wr_en), .data_out(data_out), .pending(pending),
        .overflow(overflow), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: advance the model with the inputs seen at the edge,
    // then let the timer run on.
    task automatic step();
        logic evt, drop;
        int   eff;
        logic [W-1:0] tgt;
        @(posedge clk);
        if (!n_reset) begin
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            m_held = 1'b0; m_tgt = '0; m_wr = 1'b0; m_data = '0;
            m_pend = 1'b0; m_ovf = 1'b0; m_cnt = '0;
        end else begin
            evt  = h2 & ~h3 & enable;
            eff  = (int'(delay) < MD) ? MD : int'(delay);
            tgt  = W'((int'(count) + eff) % 256);
            drop = 1'b0;
            m_wr = 1'b0;
            if (m_held) begin
                if (count == m_tgt) begin
                    drop = 1'b1; m_held = evt; m_tgt = tgt;
                end else if (!full) begin
                    m_wr = 1'b1; m_data = m_tgt; m_held = 1'b0; drop = evt;
                end else begin
                    drop = evt;
                end
            end else if (evt) begin
                m_held = 1'b1; m_tgt = tgt;
            end
            h3 = h2; h2 = h1; h1 = event_in;
            if (clr_status) begin
                m_ovf = 1'b0; m_cnt = drop ? 8'd1 : 8'd0;
            end else if (drop) begin
                m_ovf = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            m_pend = m_held;
        end
        #1;
        count = count + 8'd1;
        if (wr_en) wr_seen++;
    endtask

    // Quiet period that drains any held entry and clears the status.
    task automatic settle();
        event_in = 1'b0; full = 1'b0; enable = 1'b1;
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        for (int i = 0; i < 6; i++) step();
        wr_seen = 0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0; enable = 1'b1; event_in = 1'b0; count = 8'd0;
        delay = 8'd0; full = 1'b0; clr_status = 1'b0; wr_seen = 0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({wr_en, data_out, pending, overflow, drop_count} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b d=%0d p=%b o=%b c=%0d, want all 0",
                     wr_en, data_out, pending, overflow, drop_count);
        end
        n_reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_basic();
        settle();
        count = 8'd8; delay = 8'd20;
        for (int i = 0; i < 8; i++) begin
            event_in = (i < 3);
            step();
            checks++;
            if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                errors++;
                $display("FAIL basic_model cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                         i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
            end
            if (i == 2) begin
                checks++;
                if (pending !== 1'b1 || wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_accept: got p=%b wr=%b, want p=1 wr=0", pending, wr_en);
                end
            end
            if (i == 3) begin
                checks++;
                if (wr_en !== 1'b1 || data_out !== 8'd30) begin
                    errors++;
                    $display("FAIL basic_write: got wr=%b d=%0d, want wr=1 d=30", wr_en, data_out);
                end
            end
        end
        checks++;
        if (wr_seen != 1 || pending !== 1'b0 || overflow !== 1'b0 || data_out !== 8'd30) begin
            errors++;
            $display("FAIL basic_end: got writes=%0d p=%b o=%b d=%0d, want 1 0 0 30",
                     wr_seen, pending, overflow, data_out);
        end
    endtask

    task automatic test_wrap_clamp();
        logic [W-1:0] starts [2];
        logic [W-1:0] dlys   [2];
        logic [W-1:0] want   [2];
        starts[0] = 8'd248; dlys[0] = 8'd10; want[0] = 8'd4;
        starts[1] = 8'd48;  dlys[1] = 8'd1;  want[1] = 8'd54;
        for (int k = 0; k < 2; k++) begin
            settle();
            count = starts[k]; delay = dlys[k];
            for (int i = 0; i < 6; i++) begin
                event_in = (i < 2);
                step();
                checks++;
                if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                    errors++;
                    $display("FAIL wrap_model k%0d cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                             k, i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
                end
                if (i == 3) begin
                    checks++;
                    if (wr_en !== 1'b1 || data_out !== want[k]) begin
                        errors++;
                        $display("FAIL wrap_clamp k%0d: got wr=%b d=%0d, want wr=1 d=%0d", k, wr_en, data_out, want[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        // Release after 3 held cycles: written with target 108.
        settle();
        count = 8'd100; delay = 8'd6;
        for (int i = 0; i < 9; i++) begin
            event_in = (i < 2);
            full = (i < 6);
            step();
            checks++;
            if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                errors++;
                $display("FAIL bp_model cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                         i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
            end
            if (i == 6) begin
                checks++;
                if (wr_en !== 1'b1 || data_out !== 8'd108) begin
                    errors++;
                    $display("FAIL bp_release: got wr=%b d=%0d, want wr=1 d=108", wr_en, data_out);
                end
            end
        end
        // Full held past the target: entry expires and is dropped.
        settle();
        count = 8'd100; delay = 8'd6;
        for (int i = 0; i < 14; i++) begin
            event_in = (i < 2);
            full = (i < 11);
            step();
            checks++;
            if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                errors++;
                $display("FAIL exp_model cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                         i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
            end
        end
        checks++;
        if (wr_seen != 0 || overflow !== 1'b1 || drop_count !== 8'd1 || pending !== 1'b0) begin
            errors++;
            $display("FAIL bp_expiry: got writes=%0d o=%b c=%0d p=%b, want 0 1 1 0",
                     wr_seen, overflow, drop_count, pending);
        end
    endtask

    task automatic test_collision();
        // Second event while held under backpressure is dropped.
        settle();
        count = 8'd0; delay = 8'd100;
        for (int i = 0; i < 13; i++) begin
            event_in = (i < 2) || (i == 4);
            full = (i < 10);
            step();
            checks++;
            if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                errors++;
                $display("FAIL coll_model cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                         i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
            end
        end
        checks++;
        if (wr_seen != 1 || data_out !== 8'd102 || drop_count !== 8'd1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL coll_pend: got writes=%0d d=%0d c=%0d o=%b, want 1 102 1 1",
                     wr_seen, data_out, drop_count, overflow);
        end
        // Second event lands in the write cycle: both written, no drop.
        settle();
        count = 8'd0; delay = 8'd20;
        for (int i = 0; i < 9; i++) begin
            event_in = (i == 0) || (i == 2);
            step();
            checks++;
            if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                errors++;
                $display("FAIL coll2_model cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                         i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
            end
        end
        checks++;
        if (wr_seen != 2 || data_out !== 8'd24 || drop_count !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL coll_write: got writes=%0d d=%0d c=%0d o=%b, want 2 24 0 0",
                     wr_seen, data_out, drop_count, overflow);
        end
    endtask

    task automatic test_enable_status();
        settle();
        enable = 1'b0; delay = 8'd5;
        for (int i = 0; i < 24; i++) begin
            event_in = (i % 4) < 2;
            step();
            checks++;
            if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                errors++;
                $display("FAIL en_model cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                         i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
            end
        end
        checks++;
        if (wr_seen != 0 || drop_count !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL enable_off: got writes=%0d c=%0d o=%b, want 0 0 0", wr_seen, drop_count, overflow);
        end
        settle();
        full = 1'b1; delay = 8'd200;
        for (int i = 0; i < 640; i++) begin
            event_in = (i % 2) == 0;
            step();
            checks++;
            if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                errors++;
                $display("FAIL sat_model cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                         i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
            end
        end
        checks++;
        if (drop_count !== 8'd255 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got c=%0d o=%b, want 255 1", drop_count, overflow);
        end
        event_in = 1'b0; full = 1'b0;
        for (int i = 0; i < 5; i++) step();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        checks++;
        if (drop_count !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_status: got c=%0d o=%b, want 0 0", drop_count, overflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            settle();
            full = 1'b1; delay = 8'd50;
            for (int i = 0; i < 4; i++) begin
                event_in = (i < 2) || (k == 1);
                step();
            end
            n_reset = 1'b0;
            step();
            checks++;
            if ({wr_en, data_out, pending, overflow, drop_count} !== 19'd0) begin
                errors++;
                $display("FAIL midreset_k%0d: got wr=%b d=%0d p=%b o=%b c=%0d, want all 0",
                         k, wr_en, data_out, pending, overflow, drop_count);
            end
            n_reset = 1'b1; full = 1'b0; wr_seen = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                checks++;
                if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                    errors++;
                    $display("FAIL mid_model k%0d cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                             k, i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
                end
            end
            checks++;
            if (wr_seen != k || drop_count !== 8'd0) begin
                errors++;
                $display("FAIL midreset_writes_k%0d: got writes=%0d c=%0d, want %0d 0", k, wr_seen, drop_count, k);
            end
        end
        event_in = 1'b0;
    endtask

    task automatic test_random();
        settle();
        for (int i = 0; i < 1500; i++) begin
            event_in   = ($urandom_range(0, 2) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            full       = ($urandom_range(0, 2) == 0);
            delay      = W'($urandom_range(0, 12));
            clr_status = ($urandom_range(0, 30) == 0);
            n_reset    = ($urandom_range(0, 150) != 0);
            if ($urandom_range(0, 40) == 0) count = W'($urandom_range(0, 255));
            step();
            checks++;
            if ({wr_en, data_out, pending, overflow, drop_count} !== {m_wr, m_data, m_pend, m_ovf, m_cnt}) begin
                errors++;
                $display("FAIL rand_model cyc %0d: got wr=%b d=%0d p=%b o=%b c=%0d want wr=%b d=%0d p=%b o=%b c=%0d",
                         i, wr_en, data_out, pending, overflow, drop_count, m_wr, m_data, m_pend, m_ovf, m_cnt);
            end
        end
        n_reset = 1'b1; clr_status = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_clamp();
        test_backpressure();
        test_collision();
        test_enable_status();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
